// File: rtl/gain_arbiter.sv
// gain_arbiter: one signed gain multiplier shared by the left and right audio
// channels. A round-robin arbiter picks a channel whose input FIFO has a sample
// and whose output FIFO has room. A three-state FSM then runs
// grant -> multiply -> write-back.
// The dequantize step truncates toward zero, matching the software gain_n stage.
module gain_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int BITS       = 10,
    parameter int SHIFT      = 14 - BITS
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic signed [DATA_WIDTH-1:0] volume,
    input  logic signed [DATA_WIDTH-1:0] left_din,
    input  logic                         left_empty,
    output logic                         left_rd_en,
    input  logic signed [DATA_WIDTH-1:0] right_din,
    input  logic                         right_empty,
    output logic                         right_rd_en,
    output logic signed [DATA_WIDTH-1:0] left_dout,
    input  logic                         left_full,
    output logic                         left_wr_en,
    output logic signed [DATA_WIDTH-1:0] right_dout,
    input  logic                         right_full,
    output logic                         right_wr_en,
    output logic                         busy
);

    typedef logic signed [2*DATA_WIDTH-1:0] prod_t;
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_WRITE} state_t;

    localparam logic  CH_LEFT    = 1'b0;
    localparam logic  CH_RIGHT   = 1'b1;
    localparam prod_t ROUND_BIAS = (prod_t'(1) <<< BITS) - prod_t'(1);

    // Divide by 2^BITS rounding toward zero, then re-scale by 2^SHIFT.
    // Negative products get a bias of 2^BITS-1 so the arithmetic shift
    // truncates toward zero rather than toward minus infinity.
    function automatic logic signed [DATA_WIDTH-1:0] dequant(input prod_t p);
        prod_t biased;
        prod_t scaled;
        biased = (p < 0) ? p + ROUND_BIAS : p;
        scaled = (biased >>> BITS) <<< SHIFT;
        return scaled[DATA_WIDTH-1:0];
    endfunction

    state_t                  state;
    logic                    last;
    logic                    sel;
    logic signed [DATA_WIDTH-1:0] sample_p0;
    logic signed [DATA_WIDTH-1:0] volume_p0;
    prod_t                   product_p1;
    logic signed [DATA_WIDTH-1:0] result_p2;
    logic signed [DATA_WIDTH-1:0] left_q;
    logic signed [DATA_WIDTH-1:0] right_q;
    logic                    left_elig;
    logic                    right_elig;
    logic                    grant_left;
    logic                    grant_right;
    logic                    write_go;

    assign left_elig  = !left_empty  && !left_full;
    assign right_elig = !right_empty && !right_full;

    // Round-robin grant: a lone eligible channel always wins. On a tie the
    // channel not served last wins. Grants are suppressed while in reset.
    always_comb begin
        grant_left  = 1'b0;
        grant_right = 1'b0;
        if (reset && state == S_IDLE) begin
            if (left_elig && (!right_elig || last == CH_RIGHT)) begin
                grant_left = 1'b1;
            end else if (right_elig) begin
                grant_right = 1'b1;
            end
        end
    end

    assign left_rd_en  = grant_left;
    assign right_rd_en = grant_right;

    assign result_p2   = dequant(product_p1);
    assign left_wr_en  = (state == S_WRITE) && (sel == CH_LEFT)  && !left_full;
    assign right_wr_en = (state == S_WRITE) && (sel == CH_RIGHT) && !right_full;
    assign write_go    = left_wr_en || right_wr_en;
    assign busy        = (state != S_IDLE);

    // During write-back the served channel shows the fresh result. Otherwise
    // each channel shows the last value it actually wrote.
    assign left_dout  = (state == S_WRITE && sel == CH_LEFT)  ? result_p2 : left_q;
    assign right_dout = (state == S_WRITE && sel == CH_RIGHT) ? result_p2 : right_q;

    // Control FSM: idle/grant -> multiply -> write (stalls while output is full).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            last  <= CH_RIGHT;
            sel   <= CH_LEFT;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_left || grant_right) begin
                        sel   <= grant_right;
                        last  <= grant_right;
                        state <= S_MUL;
                    end
                end
                S_MUL: begin
                    state <= S_WRITE;
                end
                S_WRITE: begin
                    if (write_go) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Datapath: capture the sample and volume at grant, then form the full-width product.
    always_ff @(posedge clock) begin
        if (grant_left || grant_right) begin
            sample_p0 <= grant_right ? right_din : left_din;
            volume_p0 <= volume;
        end
        if (state == S_MUL) begin
            product_p1 <= prod_t'(sample_p0) * prod_t'(volume_p0);
        end
    end

    // Output holding registers: updated only when the result is pushed out.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            left_q  <= '0;
            right_q <= '0;
        end else begin
            if (left_wr_en) begin
                left_q <= result_p2;
            end
            if (right_wr_en) begin
                right_q <= result_p2;
            end
        end
    end

endmodule

// File: tb/tb_gain_arbiter.sv
// Bench for gain_arbiter. It drives modelled FWFT input FIFOs and checks the
// DUT every cycle against a transaction-level model of grant order and gain
// arithmetic. It also pins that model with hand-computed literal values.
module tb_gain_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] volume = '0;
    logic [31:0] left_din = '0;
    logic [31:0] right_din = '0;
    logic        left_empty = 1'b1;
    logic        right_empty = 1'b1;
    logic        left_full = 1'b0;
    logic        right_full = 1'b0;
    logic        left_rd_en, right_rd_en, left_wr_en, right_wr_en, busy;
    logic [31:0] left_dout, right_dout;

    gain_arbiter #(.DATA_WIDTH(32), .BITS(10), .SHIFT(4)) dut (
        .clock(clock), .reset(reset), .volume(volume),
        .left_din(left_din), .left_empty(left_empty), .left_rd_en(left_rd_en),
        .right_din(right_din), .right_empty(right_empty), .right_rd_en(right_rd_en),
        .left_dout(left_dout), .left_full(left_full), .left_wr_en(left_wr_en),
        .right_dout(right_dout), .right_full(right_full), .right_wr_en(right_wr_en),
        .busy(busy)
    );

    always #5 clock = ~clock;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [31:0] lq[$];
    logic [31:0] rq[$];
    int          glog[$];
    int          gcyc[$];
    int          last_wr_cyc = 0;
    int          lwr_cnt = 0;
    int          rwr_cnt = 0;
    int          r_strobes = 0;
    logic        pend_l = 1'b0;
    logic        pend_r = 1'b0;

    // model state
    int          m_phase = 0;
    int          m_ch = 0;
    int          m_last = 1;
    logic [31:0] m_s = '0;
    logic [31:0] m_v = '0;
    logic [31:0] m_hold_l = '0;
    logic [31:0] m_hold_r = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // C-style gain: (sample*volume)/1024 truncating toward zero, times 16, low 32 bits.
    function automatic logic [31:0] golden(input logic [31:0] s, input logic [31:0] v);
        longint p;
        longint q;
        p = longint'($signed(s)) * longint'($signed(v));
        q = p / 1024;
        q = q * 16;
        return q[31:0];
    endfunction

    function automatic void upd_pins();
        left_empty  = (lq.size() == 0);
        right_empty = (rq.size() == 0);
        left_din    = (lq.size() != 0) ? lq[0] : 32'h0;
        right_din   = (rq.size() != 0) ? rq[0] : 32'h0;
    endfunction

    task automatic push_l(input logic [31:0] v);
        lq.push_back(v);
        upd_pins();
    endtask

    task automatic push_r(input logic [31:0] v);
        rq.push_back(v);
        upd_pins();
    endtask

    task automatic clear_logs();
        glog.delete();
        gcyc.delete();
        lwr_cnt   = 0;
        rwr_cnt   = 0;
        r_strobes = 0;
    endtask

    // FWFT input FIFOs: a pop seen at the edge takes effect just after it.
    always @(posedge clock) begin
        #1;
        if (pend_l && lq.size() != 0) void'(lq.pop_front());
        if (pend_r && rq.size() != 0) void'(rq.pop_front());
        upd_pins();
    end

    // Compare process: predict every strobe and output from the model, then advance it.
    always @(negedge clock) begin
        int          gch;
        int          nxt;
        logic        e_lrd, e_rrd, e_lwr, e_rwr;
        logic [31:0] e_ld, e_rd, res;
        logic        le, re;
        cyc++;
        if (!reset) begin
            chk("rst_left_rd", left_rd_en, 0);
            chk("rst_right_rd", right_rd_en, 0);
            chk("rst_left_wr", left_wr_en, 0);
            chk("rst_right_wr", right_wr_en, 0);
            chk("rst_busy", busy, 0);
            chk("rst_left_dout", left_dout, 0);
            chk("rst_right_dout", right_dout, 0);
            m_phase  = 0;
            m_last   = 1;
            m_hold_l = '0;
            m_hold_r = '0;
            pend_l   = 1'b0;
            pend_r   = 1'b0;
        end else begin
            e_lrd = 0; e_rrd = 0; e_lwr = 0; e_rwr = 0;
            e_ld = m_hold_l; e_rd = m_hold_r;
            nxt = m_phase;
            if (m_phase == 0) begin
                le  = !left_empty && !left_full;
                re  = !right_empty && !right_full;
                gch = -1;
                if (le && (!re || m_last == 1)) gch = 0;
                else if (re) gch = 1;
                if (gch >= 0) begin
                    m_ch   = gch;
                    m_s    = (gch == 0) ? left_din : right_din;
                    m_v    = volume;
                    m_last = gch;
                    if (gch == 0) e_lrd = 1; else e_rrd = 1;
                    nxt = 1;
                end
            end else if (m_phase == 1) begin
                nxt = 2;
            end else begin
                res = golden(m_s, m_v);
                if (m_ch == 0) begin
                    e_ld  = res;
                    e_lwr = !left_full;
                    if (e_lwr) begin m_hold_l = res; nxt = 0; end
                end else begin
                    e_rd  = res;
                    e_rwr = !right_full;
                    if (e_rwr) begin m_hold_r = res; nxt = 0; end
                end
            end
            chk("left_rd_en", left_rd_en, e_lrd);
            chk("right_rd_en", right_rd_en, e_rrd);
            chk("left_wr_en", left_wr_en, e_lwr);
            chk("right_wr_en", right_wr_en, e_rwr);
            chk("busy", busy, (m_phase != 0));
            chk("left_dout", left_dout, e_ld);
            chk("right_dout", right_dout, e_rd);
            chk("strobe_overlap", (left_rd_en || right_rd_en) && (left_wr_en || right_wr_en), 0);
            if (left_rd_en)  begin glog.push_back(0); gcyc.push_back(cyc); end
            if (right_rd_en) begin glog.push_back(1); gcyc.push_back(cyc); end
            if (left_wr_en)  begin lwr_cnt++; last_wr_cyc = cyc; end
            if (right_wr_en) begin rwr_cnt++; last_wr_cyc = cyc; end
            if (right_rd_en || right_wr_en) r_strobes++;
            pend_l  = left_rd_en;
            pend_r  = right_rd_en;
            m_phase = nxt;
        end
    end

    task automatic wait_idle(input int maxc);
        int n = 0;
        while ((lq.size() != 0 || rq.size() != 0 || busy) && n < maxc) begin
            @(posedge clock); #2;
            n++;
        end
        chk("idle_wait_timeout", (n < maxc), 1);
    endtask

    task automatic wait_rd(input int ch, input int maxc);
        int   n = 0;
        logic seen = 1'b0;
        while (!seen && n < maxc) begin
            @(negedge clock);
            n++;
            seen = (ch == 0) ? left_rd_en : right_rd_en;
        end
        chk("rd_wait_timeout", seen, 1);
    endtask

    task automatic chk_order(input string nm, input int exp[]);
        chk({nm, "_count"}, glog.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            chk(nm, (i < glog.size()) ? glog[i] : -1, exp[i]);
        end
    endtask

    initial begin
        logic [31:0] lv[4];
        logic [31:0] rv[4];
        int          ord_fair[] = '{0, 1, 0, 1, 0, 1, 0, 1};
        int          ord_starve[] = '{0, 0, 1, 0, 0};

        // model pins
        chk("golden_unity", golden(32'h10, 32'h400), 32'h100);
        chk("golden_trunc", golden(32'hFFFFFFFD, 32'h200), 32'hFFFFFFF0);

        // reset state
        upd_pins();
        repeat (2) @(posedge clock);
        #2;
        chk("reset_busy", busy, 0);
        chk("reset_ldout", left_dout, 0);
        chk("reset_rdout", right_dout, 0);
        chk("reset_lrd", left_rd_en, 0);
        @(posedge clock); #3;
        reset = 1'b1;
        @(posedge clock); #2;

        // unity gain, left only
        clear_logs();
        volume = 32'h400;
        push_l(32'h10);
        wait_idle(20);
        chk_order("unity_order", '{0});
        chk("unity_latency", (gcyc.size() > 0) ? last_wr_cyc - gcyc[0] : -1, 2);
        chk("unity_ldout", left_dout, 32'h100);
        chk("unity_right_quiet", r_strobes, 0);
        chk("unity_lwr_cnt", lwr_cnt, 1);

        // truncation toward zero on right
        clear_logs();
        volume = 32'h200;
        push_r(32'hFFFFFFFD);
        wait_idle(20);
        chk("trunc_rdout", right_dout, 32'hFFFFFFF0);
        chk("trunc_ldout_held", left_dout, 32'h100);

        // fairness, both channels preloaded
        clear_logs();
        volume = 32'h300;
        lv = '{32'd1000, 32'hFFFFFC18, 32'h7FFFFFFF, 32'hFFFFFFF9};
        rv = '{32'd5, 32'hFFFFF800, 32'd123456, 32'h80000000};
        for (int i = 0; i < 4; i++) begin
            push_l(lv[i]);
            push_r(rv[i]);
        end
        wait_idle(60);
        chk_order("fair_order", ord_fair);
        chk("fair_span", (gcyc.size() > 0) ? last_wr_cyc - gcyc[0] : -1, 23);
        chk("fair_writes", lwr_cnt + rwr_cnt, 8);
        chk("fair_ldout", left_dout, 32'hFFFFFFB0);
        chk("fair_rdout", right_dout, 32'h0);

        // backpressure
        clear_logs();
        volume = 32'h400;
        left_full = 1'b1;
        push_l(32'h55);
        repeat (5) begin @(posedge clock); #2; end
        chk("bp_no_grant", glog.size(), 0);
        chk("bp_busy", busy, 0);
        left_full = 1'b0;
        wait_rd(0, 10);
        @(posedge clock); #2;
        left_full = 1'b1;
        repeat (5) begin
            @(posedge clock); #2;
            chk("bp_hold_wr", left_wr_en, 0);
            chk("bp_hold_dout", left_dout, 32'h550);
        end
        left_full = 1'b0;
        wait_idle(10);
        chk("bp_one_write", lwr_cnt, 1);
        chk("bp_final_dout", left_dout, 32'h550);

        // starvation avoidance
        clear_logs();
        right_full = 1'b1;
        push_r(32'd7);
        for (int i = 1; i <= 4; i++) push_l(i);
        for (int n = 0; n < 20 && glog.size() < 2; n++) begin @(posedge clock); #2; end
        right_full = 1'b0;
        wait_idle(40);
        chk_order("starve_order", ord_starve);
        chk("starve_period", (gcyc.size() > 1) ? gcyc[1] - gcyc[0] : -1, 3);
        chk("starve_rdout", right_dout, 32'h70);
        chk("starve_ldout", left_dout, 32'h40);

        // async reset while multiplying
        clear_logs();
        push_l(32'd9);
        wait_rd(0, 10);
        @(posedge clock); #3;
        reset = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_lwr", left_wr_en, 0);
        chk("arst_ldout", left_dout, 0);
        chk("arst_rdout", right_dout, 0);
        chk("arst_popped", lq.size(), 0);
        clear_logs();
        push_l(32'h20);
        push_r(32'h30);
        @(posedge clock); #1;
        chk("arst_rd_gated", left_rd_en, 0);
        #2;
        reset = 1'b1;
        wait_idle(20);
        chk_order("arst_order", '{0, 1});
        chk("arst_lwr_cnt", lwr_cnt, 1);
        chk("arst_ldout_new", left_dout, 32'h200);
        chk("arst_rdout_new", right_dout, 32'h300);

        repeat (2) @(posedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
